// File: rtl/dnnweaver_arb_pkg.sv
// Shared types for the dnnweaver packet arbiter.
// Grant FSM encoding and beat counter sizing.
package dnnweaver_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_0 = 2'd1,
    GRANT_1 = 2'd2
  } arb_state_t;

  // One extra bit so MAX_PKT_BEATS-1 always fits without wrap.
  function automatic int cnt_width(input int max_beats);
    return $clog2(max_beats) + 1;
  endfunction

endpackage

// File: rtl/mux_2x1.sv
// Generic 2:1 mux, optionally registered.
// The arbiter uses the combinational flavour.
module mux_2x1 #(
  parameter int    WIDTH      = 16,
  parameter string REGISTERED = "no"
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sel,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  output logic [WIDTH-1:0] out
);

  if (REGISTERED == "yes") begin : g_reg
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;

    // Select the active input for the register.
    always_comb begin
      out_d = sel ? in_1 : in_0;
    end

    // Capture the selected input.
    always_ff @(posedge clk) begin
      if (reset) out_q <= '0;
      else       out_q <= out_d;
    end

    assign out = out_q;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign out = sel ? in_1 : in_0;
  end

endmodule

// File: rtl/mux_2x1_arbiter.sv
// Round-robin packet-locked 2:1 stream arbiter.
// Grant held per packet; single registered output stage.
module mux_2x1_arbiter #(
  parameter int DATA_WIDTH    = 16,
  parameter int MAX_PKT_BEATS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid_0,
  input  logic [DATA_WIDTH-1:0] in_data_0,
  input  logic                  in_last_0,
  output logic                  in_ready_0,
  input  logic                  in_valid_1,
  input  logic [DATA_WIDTH-1:0] in_data_1,
  input  logic                  in_last_1,
  output logic                  in_ready_1,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  sel,
  output logic                  busy,
  output logic                  pkt_err
);

  import dnnweaver_arb_pkg::*;

  localparam int CW = cnt_width(MAX_PKT_BEATS);
  localparam logic [CW-1:0] CNT_LIM = CW'(MAX_PKT_BEATS - 1);

  arb_state_t state_q, state_d;
  logic rr_last_q, rr_last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic out_last_q, out_last_d;
  logic pkt_err_q, pkt_err_d;

  logic sel_s;
  logic adv;
  logic acc;
  logic ovf;
  logic eop;
  logic [DATA_WIDTH:0] mux_out;
  logic mux_last;
  logic [DATA_WIDTH-1:0] mux_data;

  assign sel_s    = (state_q == GRANT_1);
  assign adv      = !out_valid_q || out_ready;
  assign mux_last = mux_out[DATA_WIDTH];
  assign mux_data = mux_out[DATA_WIDTH-1:0];

  mux_2x1 #(
    .WIDTH(DATA_WIDTH + 1),
    .REGISTERED("no")
  ) u_mux (
    .clk  (clk),
    .reset(reset),
    .sel  (sel_s),
    .in_0 ({in_last_0, in_data_0}),
    .in_1 ({in_last_1, in_data_1}),
    .out  (mux_out)
  );

  // Beat acceptance, overlength detection and end-of-packet.
  always_comb begin
    acc = sel_s ? (in_valid_1 && in_ready_1)
                : (in_valid_0 && in_ready_0);
    ovf = acc && !mux_last && (cnt_q == CNT_LIM);
    eop = acc && (mux_last || ovf);
  end

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_last_q   <= 1'b1;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      pkt_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      pkt_err_q   <= pkt_err_d;
    end
  end

  // Next grant: arbitrate in IDLE, hand over at end of packet.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_0 && in_valid_1)
          state_d = rr_last_q ? GRANT_0 : GRANT_1;
        else if (in_valid_0)
          state_d = GRANT_0;
        else if (in_valid_1)
          state_d = GRANT_1;
      end
      GRANT_0: begin
        if (eop) state_d = in_valid_1 ? GRANT_1 : IDLE;
      end
      GRANT_1: begin
        if (eop) state_d = in_valid_0 ? GRANT_0 : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage, beat counter, round-robin and error tracking.
  always_comb begin
    rr_last_d   = rr_last_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    pkt_err_d   = pkt_err_q | ovf;
    if (acc) begin
      out_valid_d = 1'b1;
      out_data_d  = mux_data;
      out_last_d  = mux_last || ovf;
      cnt_d       = eop ? '0 : cnt_q + 1'b1;
      if (eop) rr_last_d = sel_s;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Port outputs decoded from the registered state.
  always_comb begin
    in_ready_0 = (state_q == GRANT_0) && adv;
    in_ready_1 = (state_q == GRANT_1) && adv;
    sel        = sel_s;
    busy       = (state_q != IDLE);
    out_valid  = out_valid_q;
    out_data   = out_data_q;
    out_last   = out_last_q;
    pkt_err    = pkt_err_q;
  end

endmodule

// File: tb/tb_mux_2x1_arbiter.sv
// Directed bench for mux_2x1_arbiter.
// Sources fed from queues; outputs checked against a scoreboard.
module tb_mux_2x1_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid_0, in_last_0, in_ready_0;
  logic [15:0] in_data_0;
  logic        in_valid_1, in_last_1, in_ready_1;
  logic [15:0] in_data_1;
  logic        out_valid, out_last, out_ready;
  logic [15:0] out_data;
  logic        sel, busy, pkt_err;

  always #5 clk = ~clk;

  mux_2x1_arbiter #(
    .DATA_WIDTH(16),
    .MAX_PKT_BEATS(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid_0(in_valid_0),
    .in_data_0 (in_data_0),
    .in_last_0 (in_last_0),
    .in_ready_0(in_ready_0),
    .in_valid_1(in_valid_1),
    .in_data_1 (in_data_1),
    .in_last_1 (in_last_1),
    .in_ready_1(in_ready_1),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .sel       (sel),
    .busy      (busy),
    .pkt_err   (pkt_err)
  );

  logic [16:0] s0[$];
  logic [16:0] s1[$];
  logic [16:0] sb[$];
  int gq[$];
  int acc_cyc[$];
  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;
  int base;

  function automatic logic [16:0] bt(input logic [15:0] d,
                                     input logic l);
    return {l, d};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic drive();
    in_valid_0 = (s0.size() != 0);
    in_data_0  = (s0.size() != 0) ? s0[0][15:0] : 16'h0;
    in_last_0  = (s0.size() != 0) ? s0[0][16] : 1'b0;
    in_valid_1 = (s1.size() != 0);
    in_data_1  = (s1.size() != 0) ? s1[0][15:0] : 16'h0;
    in_last_1  = (s1.size() != 0) ? s1[0][16] : 1'b0;
  endtask

  task automatic cycle();
    logic a0, a1;
    int g;
    logic [17:0] e;
    @(negedge clk);
    a0 = in_valid_0 && in_ready_0;
    a1 = in_valid_1 && in_ready_1;
    if (a0 || a1) begin
      g = (gq.size() != 0) ? gq.pop_front() : 2;
      chk("gnt_req", {31'd0, a1}, g);
      chk("gnt_sel", {31'd0, sel}, g);
      acc_cyc.push_back(cyc);
    end
    if (out_valid && out_ready) begin
      e = (sb.size() != 0) ? {1'b0, sb.pop_front()} : 18'h3ffff;
      chk("out_beat", {14'd0, 1'b0, out_last, out_data}, {14'd0, e});
    end
    @(posedge clk);
    #1;
    cyc++;
    if (a0) void'(s0.pop_front());
    if (a1) void'(s1.pop_front());
    drive();
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || gq.size() != 0) && n < 200) begin
      cycle();
      n++;
    end
    chk("drain_left", sb.size() + gq.size(), 0);
    sb.delete();
    gq.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    drive();
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    drive();
    cycle();
    cycle();
    reset = 1'b0;
    drive();

    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pkt_err", pkt_err, 0);
    chk("rst_ready0", in_ready_0, 0);
    chk("rst_ready1", in_ready_1, 0);

    // single requester, 3-beat packet
    acc_cyc.delete();
    s0.push_back(bt(16'h0011, 0));
    s0.push_back(bt(16'h0022, 0));
    s0.push_back(bt(16'h0033, 1));
    sb.push_back(bt(16'h0011, 0));
    sb.push_back(bt(16'h0022, 0));
    sb.push_back(bt(16'h0033, 1));
    repeat (3) gq.push_back(0);
    base = cyc;
    drive();
    drain();
    chk("t1_acc0", acc_cyc[0], base + 1);
    chk("t1_acc1", acc_cyc[1], base + 2);
    chk("t1_acc2", acc_cyc[2], base + 3);
    chk("t1_idle", busy, 0);

    // tie from reset, handover without bubble
    do_reset();
    acc_cyc.delete();
    s0.push_back(bt(16'h0A01, 0));
    s0.push_back(bt(16'h0A02, 1));
    s1.push_back(bt(16'h0B01, 0));
    s1.push_back(bt(16'h0B02, 1));
    sb.push_back(bt(16'h0A01, 0));
    sb.push_back(bt(16'h0A02, 1));
    sb.push_back(bt(16'h0B01, 0));
    sb.push_back(bt(16'h0B02, 1));
    gq.push_back(0); gq.push_back(0);
    gq.push_back(1); gq.push_back(1);
    drive();
    drain();
    chk("t2_nobubble", acc_cyc[2] - acc_cyc[1], 1);

    // backpressure mid-packet
    for (int i = 1; i <= 4; i++) begin
      s0.push_back(bt(16'h0C00 + 16'(i), i == 4));
      sb.push_back(bt(16'h0C00 + 16'(i), i == 4));
      gq.push_back(0);
    end
    drive();
    repeat (3) cycle();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("bp_data", out_data, 16'h0C02);
      chk("bp_last", out_last, 0);
      chk("bp_valid", out_valid, 1);
      chk("bp_ready0", in_ready_0, 0);
    end
    out_ready = 1'b1;
    drain();

    // fairness against back-to-back requester 0 packets
    acc_cyc.delete();
    for (int i = 1; i <= 4; i++)
      s0.push_back(bt(16'h0E00 + 16'(i), 1));
    sb.push_back(bt(16'h0E01, 1));
    sb.push_back(bt(16'h0F01, 1));
    sb.push_back(bt(16'h0E02, 1));
    sb.push_back(bt(16'h0E03, 1));
    sb.push_back(bt(16'h0E04, 1));
    gq.push_back(0); gq.push_back(1); gq.push_back(0);
    gq.push_back(0); gq.push_back(0);
    drive();
    cycle();
    s1.push_back(bt(16'h0F01, 1));
    drive();
    drain();
    chk("fair_r1_next", acc_cyc[1] - acc_cyc[0], 1);
    chk("fair_r0_back", acc_cyc[2] - acc_cyc[1], 1);

    // overlength packet from requester 1
    chk("ovl_err_before", pkt_err, 0);
    acc_cyc.delete();
    for (int i = 1; i <= 6; i++) begin
      s1.push_back(bt(16'h0D00 + 16'(i), 0));
      sb.push_back(bt(16'h0D00 + 16'(i), i == 4));
      gq.push_back(1);
    end
    drive();
    drain();
    chk("ovl_rearb", acc_cyc[4] - acc_cyc[3], 2);
    chk("ovl_err", pkt_err, 1);
    cycle();
    chk("ovl_err_sticky", pkt_err, 1);
    chk("ovl_busy", busy, 1);
    s1.push_back(bt(16'h0D07, 1));
    sb.push_back(bt(16'h0D07, 1));
    gq.push_back(1);
    drive();
    drain();
    chk("ovl_err_hold", pkt_err, 1);

    // reset on the second beat of a packet
    s0.push_back(bt(16'h0701, 0));
    s0.push_back(bt(16'h0702, 0));
    s0.push_back(bt(16'h0703, 1));
    sb.push_back(bt(16'h0701, 0));
    gq.push_back(0); gq.push_back(0);
    drive();
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    s0.delete();
    drive();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_err", pkt_err, 0);
    chk("mrst_sel", sel, 0);
    chk("mrst_sb", sb.size() + gq.size(), 0);
    s0.push_back(bt(16'h0801, 1));
    s1.push_back(bt(16'h0901, 1));
    sb.push_back(bt(16'h0801, 1));
    sb.push_back(bt(16'h0901, 1));
    gq.push_back(0); gq.push_back(1);
    drive();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_2x1_arbiter.md
Name: mux_2x1_arbiter

Overview:
Round-robin, packet-locked arbiter that shares one downstream stream port between two upstream requesters.
It drives the select of a 2:1 data mux and holds the grant for a whole packet, from the first beat through the beat flagged last.
The muxed beat is captured in a single registered output stage with a valid/ready handshake.
It sits in front of shared dnnweaver datapath resources, for example a shared write channel or a shared PE input bus.

Parameters:
DATA_WIDTH, 16, width of each data beat.
MAX_PKT_BEATS, 256, packet-length limit; sizes the beat counter; a longer packet raises pkt_err.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
in_valid_0  in  1  requester 0 beat valid.
in_data_0  in  DATA_WIDTH  requester 0 beat data.
in_last_0  in  1  requester 0 final beat of packet.
in_ready_0  out  1  requester 0 beat accepted this cycle when in_valid_0 is also high.
in_valid_1, in_data_1, in_last_1, in_ready_1: same as the requester 0 ports, for requester 1.
out_valid  out  1  output beat valid (registered).
out_data  out  DATA_WIDTH  output beat data (registered).
out_last  out  1  output final beat (registered).
out_ready  in  1  downstream accepts the beat.
sel  out  1  current grant (0 or 1), registered; meaningful only when busy=1.
busy  out  1  a packet is in progress (state is not IDLE).
pkt_err  out  1  sticky; set when a packet exceeds MAX_PKT_BEATS beats.

Behaviour:
- Reset values:
  - state=IDLE; out_valid=0, out_data=0, out_last=0.
  - sel=0, busy=0, pkt_err=0, beat_cnt=0.
  - rr_last=1, so requester 0 wins the first tie.
- FSM states: IDLE, GRANT_0, GRANT_1. sel=1 only in GRANT_1; busy=1 in GRANT_0 and GRANT_1.
- IDLE:
  - Only one in_valid high: go to that GRANT state.
  - Both high: go to GRANT for the requester not equal to rr_last.
  - Neither high: stay in IDLE.
  - in_ready_0 and in_ready_1 are both 0 in IDLE; arbitration costs one cycle.
- Output-stage enable: adv = !out_valid || out_ready.
- Ready rule: in_ready_i = (state==GRANT_i) && adv. The non-granted requester always sees ready=0.
- Accept on in_valid_i && in_ready_i:
  - out_data <= in_data_i, out_last <= in_last_i, out_valid <= 1.
  - beat_cnt increments.
- Output drain: if out_valid && out_ready and nothing is accepted that cycle, out_valid <= 0. out_data and out_last hold their values.
- Latency: a beat accepted in cycle N is presented in cycle N+1. With out_ready held high, throughput is one beat per cycle.
- Backpressure: while out_valid && !out_ready, all out_* fields are held stable and in_ready_0 and in_ready_1 are both 0.
- End of packet, when a beat with in_last_i is accepted:
  - rr_last <= i and beat_cnt <= 0.
  - Same cycle: if in_valid of the other requester is high, go directly to GRANT_other with no IDLE bubble.
  - Otherwise go to IDLE. Never re-grant i directly: fairness is preserved.
- A grant is never revoked mid-packet, even if the requester drops valid; ready simply waits.
- Packet length error:
  - If a non-last beat is accepted with beat_cnt == MAX_PKT_BEATS-1, set pkt_err (sticky until reset).
  - That beat is forwarded with out_last forced to 1; the FSM then releases exactly as on a true last beat.
- Reset mid-packet: all state returns to reset values on the next edge; a partially delivered packet is abandoned, with no flush.
- Counter width: $clog2(MAX_PKT_BEATS)+1 bits; the counter never wraps.

Decomposition:
- Shared package dnnweaver_arb_pkg:
  - arb_state_t enum (IDLE, GRANT_0, GRANT_1).
  - localparam function for the counter width.
- Natural sub-module: reuse mux_2x1 with REGISTERED="no" for data/last selection, driven by the sel state bit.
- The output register stage stays inline in mux_2x1_arbiter.

Test Plan:
- Reset, then in_valid_0=1 only with a 3-beat packet (data 0x0011, 0x0022, 0x0033; last on beat 3), out_ready=1:
  - sel=0.
  - out_valid cycles 2-4 with data in order; out_last only on 0x0033.
  - Returns to IDLE.
- Both valid from reset, each with 2-beat packets:
  - Requester 0 is served first.
  - Then GRANT_1 with no IDLE cycle between out_last of packet 0 and the first beat of packet 1.
  - Order of sel values: 0, 0, 1, 1.
- Backpressure: out_ready=0 for 4 cycles mid-packet:
  - out_data and out_last stay stable.
  - in_ready_0=0 throughout.
  - No beats lost or duplicated after release.
- Fairness: requester 0 sends back-to-back 1-beat packets continuously, requester 1 asserts valid once:
  - Requester 1 is granted immediately after the current requester 0 packet.
  - Grants then alternate 0, 1, 0.
- Overlength: MAX_PKT_BEATS=4, requester 1 sends 6 beats without last:
  - Beat 4 is output with out_last=1 and pkt_err=1 sticky.
  - Beats 5-6 form a new packet after re-arbitration.
- Reset asserted on the second beat of a 3-beat packet:
  - Next cycle out_valid=0, busy=0, pkt_err=0.
  - A subsequent tie is won by requester 0.
